// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// Holds the FSM encoding, the fetch NOP substitute and default limits.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ_I,
        REQ_D,
        WAIT_I,
        WAIT_D
    } arb_state_e;

    localparam logic [31:0] NOP_INSN      = 32'h0000_0013;
    localparam int          TIMEOUT_DEF   = 255;
    localparam int          MAX_D_RUN_DEF = 4;
    localparam int          CNT_W         = 16;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Loadable up-counter with clear/enable and terminal-count compare; saturates at all-ones.
// Latency: count updates one cycle after clr/ld/en; tc is combinational from the count.
// Backpressure: none, purely a timer.
module arb_timeout_cnt
    import mem_arb_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         en,
    input  logic [W-1:0] term_val,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (ld) begin
            cnt_d = ld_val;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == term_val);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store onto one memory port, data priority; ARB_STARVE_GUARD_EN adds a fetch starvation guard.
// Latency: 3 cycles minimum request-to-done (grant, request, wait), done registered.
// Backpressure: holds mem_req/addr stable while mem_ready=0; core stalls until its done pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int MAX_D_RUN = MAX_D_RUN_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall,
    output logic          err_timeout
);

    arb_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          i_done_q, i_done_d;
    logic          d_done_q, d_done_d;
    logic          err_q, err_d;
    logic          cnt_clr, cnt_en, cnt_tc;
    logic          grant_d, grant_i;

`ifdef ARB_STARVE_GUARD_EN
    logic [CNT_W-1:0] run_q, run_d;
    logic             force_i;

    // Once data has won MAX_D_RUN grants in a row over a waiting fetch, fetch goes next.
    assign force_i = i_req && (run_q >= CNT_W'(MAX_D_RUN));
    assign grant_d = d_req && !force_i;

    always_comb begin
        run_d = run_q;
        if (state_q == IDLE) begin
            if (grant_d) begin
                run_d = i_req ? run_q + 1'b1 : '0;
            end else if (i_req) begin
                run_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end
`else
    assign grant_d = d_req;
`endif
    assign grant_i = i_req && !grant_d;

    arb_timeout_cnt #(.W(CNT_W)) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .ld       (1'b0),
        .ld_val   ('0),
        .en       (cnt_en),
        .term_val (CNT_W'(TIMEOUT - 1)),
        .tc       (cnt_tc)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        err_d     = err_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = REQ_D;
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                end else if (grant_i) begin
                    state_d = REQ_I;
                    addr_d  = i_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                end
            end
            REQ_I: begin
                if (mem_ready) begin
                    state_d = WAIT_I;
                    cnt_clr = 1'b1;
                end
            end
            REQ_D: begin
                if (mem_ready) begin
                    state_d = WAIT_D;
                    cnt_clr = 1'b1;
                end
            end
            WAIT_I: begin
                cnt_en = 1'b1;
                if (mem_rvalid) begin
                    i_rdata_d = mem_rdata;
                    i_done_d  = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_tc) begin
                    // A lost fetch executes as a NOP so the core keeps running.
                    i_rdata_d = DW'(NOP_INSN);
                    i_done_d  = 1'b1;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end
            end
            WAIT_D: begin
                cnt_en = 1'b1;
                if (mem_rvalid) begin
                    d_rdata_d = mem_rdata;
                    d_done_d  = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_tc) begin
                    d_rdata_d = '0;
                    d_done_d  = 1'b1;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            err_q     <= err_d;
        end
    end

    assign mem_req     = (state_q == REQ_I) || (state_q == REQ_D);
    assign mem_we      = mem_req && we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign i_done      = i_done_q;
    assign i_rdata     = i_rdata_q;
    assign d_done      = d_done_q;
    assign d_rdata     = d_rdata_q;
    assign err_timeout = err_q;
    assign stall       = (i_req && !i_done_q) || (d_req && !d_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a behavioural memory and core model.
module tb_mem_port_arbiter;

    localparam int          TMO = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_done, d_done;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_req, mem_we, mem_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall, err_timeout;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO), .MAX_D_RUN(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall(stall), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        bit          stable;
        int          req_cycles;
        int          cyc;
    } acc_t;

    acc_t        acc_q[$];
    acc_t        cur;
    logic [31:0] mem_m [logic [31:0]];

    int checks = 0, errors = 0;
    int rdy_lat, rv_lat;
    bit no_resp, d_renew;
    int i_done_n = 0, d_done_n = 0, i_done_cyc = 0, d_done_cyc = 0;
    logic [31:0] i_got, d_got;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory model: accepts after rdy_lat refused cycles, answers rv_lat cycles later.
    bit          rsp_busy = 0, rsp_seen = 0;
    int          rsp_wait = 0, rsp_left = 0;
    logic [31:0] rsp_data;
    initial begin
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
            if (rsp_busy) begin
                rsp_wait--;
                if (rsp_wait <= 0) begin
                    rsp_busy = 0;
                    if (!no_resp) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rsp_data;
                    end
                end
            end else if (mem_req) begin
                if (!rsp_seen) begin
                    rsp_seen = 1; rsp_left = rdy_lat;
                    cur.addr = mem_addr; cur.stable = 1; cur.req_cycles = 0;
                end
                cur.req_cycles++;
                if (mem_addr !== cur.addr) cur.stable = 0;
                if (rsp_left == 0) begin
                    mem_ready = 1'b1;
                    cur.we = mem_we; cur.wdata = mem_wdata; cur.cyc = cyc;
                    rsp_data = mem_we ? 32'h0 : rd_model(mem_addr);
                    acc_q.push_back(cur);
                    rsp_seen = 0; rsp_busy = 1; rsp_wait = rv_lat;
                end else begin
                    rsp_left--;
                end
            end else if (rsp_seen) begin
                cur.stable = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Core model: one cycle forward; on done, capture data and drop (or renew) the request.
    task automatic step();
        @(negedge clk);
        #1;
        if (d_done) begin
            d_got = d_rdata; d_done_n++; d_done_cyc = cyc;
            if (d_renew) begin
                d_addr = d_addr + 32'd4;
                d_we   = 1'b0;
            end else begin
                d_req = 1'b0;
            end
        end
        if (i_done) begin
            i_got = i_rdata; i_done_n++; i_done_cyc = cyc;
            i_req = 1'b0;
        end
    endtask

    task automatic wait_both(input string tag, input int ti, input int td, input int budget);
        int k = 0;
        while ((i_done_n < ti || d_done_n < td) && k < budget) begin
            step();
            k++;
        end
        chk({tag, "_i_done_count"}, i_done_n, ti);
        chk({tag, "_d_done_count"}, d_done_n, td);
    endtask

    task automatic chk_acc(input string tag, input logic [31:0] addr, input logic we,
                           input logic [31:0] wdata, output int acyc, output int nreq);
        acc_t r;
        acyc = 0; nreq = 0;
        chk({tag, "_issued"}, 32'(acc_q.size() > 0), 1);
        if (acc_q.size() > 0) begin
            r = acc_q.pop_front();
            chk({tag, "_addr"}, r.addr, addr);
            chk({tag, "_we"}, 32'(r.we), 32'(we));
            if (we) chk({tag, "_wdata"}, r.wdata, wdata);
            chk({tag, "_stable"}, 32'(r.stable), 1);
            acyc = r.cyc; nreq = r.req_cycles;
        end
    endtask

    initial begin
        int          t0, ni, nd, ac, nr, ac2, mode, k;
        logic [31:0] exp_i, exp_d;
        logic [5:0]  exp_is_i;

        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        rdy_lat = 0; rv_lat = 1; no_resp = 0; d_renew = 0;
        mem_m[32'h100] = 32'h0050_0093;
        repeat (3) step();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_i_done", 32'(i_done), 0);
        chk("rst_d_done", 32'(d_done), 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_err", 32'(err_timeout), 0);
        chk("rst_stall", 32'(stall), 0);
        rst = 1'b0;
        step();

        // Lone fetch, minimum latency.
        acc_q.delete(); ni = i_done_n;
        i_addr = 32'h100; i_req = 1'b1; t0 = cyc;
        #1 chk("t1_stall_busy", 32'(stall), 1);
        wait_both("t1", ni + 1, d_done_n, 20);
        chk("t1_latency", i_done_cyc - t0, 3);
        chk("t1_rdata", i_got, 32'h0050_0093);
        chk_acc("t1", 32'h100, 1'b0, 32'h0, ac, nr);
        step();
        chk("t1_stall_after", 32'(stall), 0);
        chk("t1_done_low", 32'(i_done), 0);
        chk("t1_single_pulse", i_done_n - ni, 1);

        // Simultaneous store and fetch: store first, one idle cycle, then fetch.
        acc_q.delete(); ni = i_done_n; nd = d_done_n;
        d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; mem_m[32'h2000] = 32'hDEAD_BEEF;
        i_addr = 32'h104; exp_i = rd_model(32'h104);
        d_req = 1'b1; i_req = 1'b1;
        wait_both("t2", ni + 1, nd + 1, 40);
        chk_acc("t2_store", 32'h2000, 1'b1, 32'hDEAD_BEEF, ac, nr);
        chk_acc("t2_fetch", 32'h104, 1'b0, 32'h0, ac2, nr);
        chk("t2_idle_gap", ac2 - d_done_cyc, 1);
        chk("t2_fetch_after_store", i_done_cyc - d_done_cyc, 3);
        chk("t2_fetch_rdata", i_got, exp_i);

        // Memory refuses for 5 cycles.
        acc_q.delete(); nd = d_done_n; rdy_lat = 5;
        d_we = 1'b0; d_addr = 32'h3000; exp_d = rd_model(32'h3000);
        d_req = 1'b1; t0 = cyc;
        wait_both("t3", i_done_n, nd + 1, 40);
        chk_acc("t3", 32'h3000, 1'b0, 32'h0, ac, nr);
        chk("t3_req_cycles", nr, 6);
        chk("t3_latency", d_done_cyc - t0, 8);
        chk("t3_rdata", d_got, exp_d);
        repeat (3) step();
        chk("t3_rdata_hold", d_rdata, exp_d);
        rdy_lat = 0;

        // Timeout on a load, then on a fetch.
        acc_q.delete(); nd = d_done_n; no_resp = 1;
        d_addr = 32'h3000; d_req = 1'b1;
        wait_both("t4d", i_done_n, nd + 1, 40);
        chk_acc("t4d", 32'h3000, 1'b0, 32'h0, ac, nr);
        chk("t4d_wait_cycles", d_done_cyc - ac, TMO + 1);
        chk("t4d_rdata_zero", d_got, 0);
        chk("t4d_err", 32'(err_timeout), 1);
        repeat (10) step();
        chk("t4_err_sticky", 32'(err_timeout), 1);
        acc_q.delete(); ni = i_done_n;
        i_addr = 32'h100; i_req = 1'b1;
        wait_both("t4i", ni + 1, d_done_n, 40);
        chk_acc("t4i", 32'h100, 1'b0, 32'h0, ac, nr);
        chk("t4i_wait_cycles", i_done_cyc - ac, TMO + 1);
        chk("t4i_rdata_nop", i_got, NOP);
        no_resp = 0;

        // Reset while waiting for a load; the late response must be ignored.
        acc_q.delete(); nd = d_done_n; rv_lat = 6;
        d_we = 1'b0; d_addr = 32'h2000; d_req = 1'b1;
        k = 0;
        while (acc_q.size() == 0 && k < 20) begin step(); k++; end
        chk("t5_issued", acc_q.size(), 1);
        repeat (2) step();
        rst = 1'b1; d_req = 1'b0;
        step();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            chk("t5_no_done", 32'(d_done), 0);
        end
        chk("t5_done_count", d_done_n, nd);
        chk("t5_no_reissue", acc_q.size(), 1);
        chk("t5_mem_req", 32'(mem_req), 0);
        chk("t5_mem_we", 32'(mem_we), 0);
        chk("t5_mem_addr", mem_addr, 0);
        chk("t5_d_rdata", d_rdata, 0);
        chk("t5_i_rdata", i_rdata, 0);
        chk("t5_err_cleared", 32'(err_timeout), 0);
        chk("t5_stall", 32'(stall), 0);
        acc_q.delete();

        // Randomized single and paired transactions.
        for (int it = 0; it < 30; it++) begin
            mode = $urandom_range(1, 3);
            rdy_lat = $urandom_range(0, 3);
            rv_lat  = $urandom_range(1, 3);
            acc_q.delete(); ni = i_done_n; nd = d_done_n;
            exp_i = '0; exp_d = '0;
            if (mode != 2) begin
                i_addr = 32'h100 + 32'(4 * $urandom_range(0, 15));
                exp_i = rd_model(i_addr);
            end
            if (mode != 1) begin
                d_addr  = 32'h2000 + 32'(4 * $urandom_range(0, 7));
                d_we    = 1'($urandom_range(0, 1));
                d_wdata = $urandom;
                if (d_we) mem_m[d_addr] = d_wdata;
                else exp_d = rd_model(d_addr);
            end
            t0 = cyc;
            i_req = (mode != 2);
            d_req = (mode != 1);
            wait_both("rnd", ni + ((mode != 2) ? 1 : 0), nd + ((mode != 1) ? 1 : 0), 60);
            if (mode != 1) begin
                chk_acc("rnd_d", d_addr, d_we, d_wdata, ac, nr);
                chk("rnd_d_ready_wait", nr, rdy_lat + 1);
                if (!d_we) chk("rnd_d_rdata", d_got, exp_d);
            end
            if (mode != 2) begin
                chk_acc("rnd_i", i_addr, 1'b0, 32'h0, ac, nr);
                chk("rnd_i_rdata", i_got, exp_i);
            end
            if (mode == 1) chk("rnd_i_latency", i_done_cyc - t0, 2 + rdy_lat + rv_lat);
            if (mode == 2) chk("rnd_d_latency", d_done_cyc - t0, 2 + rdy_lat + rv_lat);
            if (mode == 3) chk("rnd_pair_spacing", i_done_cyc - d_done_cyc, 2 + rdy_lat + rv_lat);
            step();
            chk("rnd_stall_idle", 32'(stall), 0);
        end

        // Continuous data stream competing with one waiting fetch.
        acc_q.delete(); ni = i_done_n; rdy_lat = 0; rv_lat = 1;
`ifdef ARB_STARVE_GUARD_EN
        exp_is_i = 6'b01_0000;
`else
        exp_is_i = 6'b00_0000;
`endif
        d_renew = 1; d_we = 1'b0; d_addr = 32'h5000; i_addr = 32'h180;
        d_req = 1'b1; i_req = 1'b1;
        k = 0;
        while (acc_q.size() < 6 && k < 80) begin step(); k++; end
        chk("t7_grants", 32'(acc_q.size() >= 6), 1);
        for (int g = 0; g < 6; g++) begin
            if (g < acc_q.size())
                chk($sformatf("t7_grant%0d_is_fetch", g), 32'(acc_q[g].addr == 32'h180), 32'(exp_is_i[g]));
        end
        d_renew = 0;
        k = 0;
        while ((d_req || i_req) && k < 80) begin step(); k++; end
        chk("t7_drained", 32'({i_req, d_req}), 0);
        chk("t7_fetch_done_once", i_done_n - ni, 1);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
